// File: rtl/execute_pred_stage.sv
// Y86 execute stage: ALU, condition codes, jXX/cmovXX evaluation and a saturating-counter branch predictor.
// Optional macro EXEC_STATS_EN adds the br_count / mispred_count statistics outputs.
module execute_pred_stage #(
   parameter int DATA_W     = 32,
   parameter int PRED_IDX_W = 4,
   parameter int CTR_W      = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              in_valid,
   input  logic [3:0]        icode,
   input  logic [3:0]        ifun,
   input  logic [3:0]        rA,
   input  logic [3:0]        rB,
   input  logic [DATA_W-1:0] valA,
   input  logic [DATA_W-1:0] valB,
   input  logic [DATA_W-1:0] valC,
   input  logic [DATA_W-1:0] valP,
   input  logic              pred,
   input  logic [DATA_W-1:0] f_pc,
   output logic              f_pred,
   output logic              out_valid,
   output logic [3:0]        icode_out,
   output logic [3:0]        rA_out,
   output logic [3:0]        rB_out,
   output logic [DATA_W-1:0] valA_out,
   output logic [DATA_W-1:0] valE,
   output logic [DATA_W-1:0] valP_out,
   output logic              cnd,
   output logic              wrong_pred,
`ifdef EXEC_STATS_EN
   output logic [31:0]       br_count,
   output logic [31:0]       mispred_count,
`endif
   output logic [DATA_W-1:0] redirect_pc
);

   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_CMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPL   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;
   localparam logic [3:0] R_NONE  = 4'hF;

   localparam int                DEPTH      = 1 << PRED_IDX_W;
   localparam logic [DATA_W-1:0] WORD_BYTES = DATA_W'(DATA_W / 8);
   localparam logic [CTR_W-1:0]  CTR_INIT   = CTR_W'((1 << (CTR_W - 1)) - 1);
   localparam logic [CTR_W-1:0]  CTR_MAX    = '1;

   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_t;

   cc_t                   cc_q, cc_d;
   logic                  cc_wr;
   logic [DATA_W-1:0]     alu_val;
   logic                  cond;
   logic                  fire;
   logic                  is_jxx;
   logic [PRED_IDX_W-1:0] train_idx;
   logic [CTR_W-1:0]      pred_tbl [DEPTH];
   logic                  unused_f_pc;

   assign fire        = in_valid && !stall;
   assign is_jxx      = (icode == I_JXX);
   assign train_idx   = valP[PRED_IDX_W-1:0];
   assign unused_f_pc = ^f_pc[DATA_W-1:PRED_IDX_W];

   // Read is the registered table, so a same-cycle train is not visible until next cycle.
   assign f_pred = pred_tbl[f_pc[PRED_IDX_W-1:0]][CTR_W-1];

   // NOTE: every variable gets a default first so no latch is inferred on unlisted cases.
   always_comb begin
      alu_val = '0;
      cc_d    = cc_q;
      cc_wr   = 1'b0;
      case (icode)
         I_CMOV:           alu_val = valA;
         I_IRMOV:          alu_val = valC;
         I_RMMOV, I_MRMOV: alu_val = valB + valC;
         I_OPL: begin
            case (ifun)
               4'd0:    alu_val = valB + valA;
               4'd1:    alu_val = valB - valA;
               4'd2:    alu_val = valB & valA;
               4'd3:    alu_val = valB ^ valA;
               default: alu_val = '0;
            endcase
         end
         I_CALL, I_PUSH:   alu_val = valB - WORD_BYTES;
         I_RET, I_POP:     alu_val = valB + WORD_BYTES;
         default:          alu_val = '0;
      endcase

      if (icode == I_OPL && ifun <= 4'd3) begin
         cc_wr   = 1'b1;
         cc_d.zf = (alu_val == '0);
         cc_d.sf = alu_val[DATA_W-1];
         case (ifun)
            4'd0:    cc_d.of = (valA[DATA_W-1] == valB[DATA_W-1]) &&
                               (alu_val[DATA_W-1] != valB[DATA_W-1]);
            4'd1:    cc_d.of = (valA[DATA_W-1] != valB[DATA_W-1]) &&
                               (alu_val[DATA_W-1] != valB[DATA_W-1]);
            default: cc_d.of = 1'b0;
         endcase
      end
   end

   // Conditions always use the flags from before this instruction.
   always_comb begin
      cond = 1'b0;
      case (ifun)
         4'd0:    cond = 1'b1;
         4'd1:    cond = (cc_q.sf ^ cc_q.of) | cc_q.zf;
         4'd2:    cond = cc_q.sf ^ cc_q.of;
         4'd3:    cond = cc_q.zf;
         4'd4:    cond = !cc_q.zf;
         4'd5:    cond = !(cc_q.sf ^ cc_q.of);
         4'd6:    cond = !(cc_q.sf ^ cc_q.of) && !cc_q.zf;
         default: cond = 1'b0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cc_q <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
      end else if (fire && cc_wr) begin
         cc_q <= cc_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid   <= 1'b0;
         icode_out   <= I_NOP;
         rA_out      <= R_NONE;
         rB_out      <= R_NONE;
         valA_out    <= '0;
         valE        <= '0;
         valP_out    <= '0;
         cnd         <= 1'b0;
         wrong_pred  <= 1'b0;
         redirect_pc <= '0;
      end else if (!stall) begin
         if (in_valid) begin
            out_valid   <= 1'b1;
            icode_out   <= icode;
            rA_out      <= rA;
            rB_out      <= (icode == I_CMOV && !cond) ? R_NONE : rB;
            valA_out    <= valA;
            valE        <= alu_val;
            valP_out    <= valP;
            cnd         <= (icode == I_CMOV || is_jxx) ? cond : 1'b0;
            wrong_pred  <= is_jxx && (pred != cond);
            redirect_pc <= is_jxx ? (cond ? valC : valP) : '0;
         end else begin
            out_valid   <= 1'b0;
            icode_out   <= I_NOP;
            rA_out      <= R_NONE;
            rB_out      <= R_NONE;
            valA_out    <= '0;
            valE        <= '0;
            valP_out    <= '0;
            cnd         <= 1'b0;
            wrong_pred  <= 1'b0;
            redirect_pc <= '0;
         end
      end
   end

   // NOTE: the predictor table is reset entry by entry, so it maps to flops rather than RAM.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pred_tbl[i] <= CTR_INIT;
         end
      end else if (fire && is_jxx) begin
         if (cond && pred_tbl[train_idx] != CTR_MAX) begin
            pred_tbl[train_idx] <= pred_tbl[train_idx] + CTR_W'(1);
         end else if (!cond && pred_tbl[train_idx] != '0) begin
            pred_tbl[train_idx] <= pred_tbl[train_idx] - CTR_W'(1);
         end
      end
   end

`ifdef EXEC_STATS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         br_count      <= '0;
         mispred_count <= '0;
      end else if (fire && is_jxx) begin
         br_count <= br_count + 32'd1;
         if (pred != cond) begin
            mispred_count <= mispred_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_execute_pred_stage.sv
// Directed self-checking bench for execute_pred_stage (default parameters).
// Define EXEC_STATS_EN to also exercise the statistics counters.
module tb_execute_pred_stage;

   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          stall = 1'b0;
   logic          in_valid = 1'b0;
   logic [3:0]    icode = 4'h1, ifun = 4'h0, rA = 4'hF, rB = 4'hF;
   logic [DW-1:0] valA = '0, valB = '0, valC = '0, valP = '0, f_pc = '0;
   logic          pred = 1'b0;
   logic          f_pred, out_valid, cnd, wrong_pred;
   logic [3:0]    icode_out, rA_out, rB_out;
   logic [DW-1:0] valA_out, valE, valP_out, redirect_pc;
`ifdef EXEC_STATS_EN
   logic [31:0]   br_count, mispred_count;
`endif

   int total = 0;
   int bad   = 0;

   execute_pred_stage #(.DATA_W(DW), .PRED_IDX_W(4), .CTR_W(2)) dut (
      .clock(clock), .reset(reset), .stall(stall), .in_valid(in_valid),
      .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
      .valA(valA), .valB(valB), .valC(valC), .valP(valP),
      .pred(pred), .f_pc(f_pc), .f_pred(f_pred),
      .out_valid(out_valid), .icode_out(icode_out), .rA_out(rA_out), .rB_out(rB_out),
      .valA_out(valA_out), .valE(valE), .valP_out(valP_out),
      .cnd(cnd), .wrong_pred(wrong_pred),
`ifdef EXEC_STATS_EN
      .br_count(br_count), .mispred_count(mispred_count),
`endif
      .redirect_pc(redirect_pc)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [DW-1:0] p, input logic pr);
      in_valid = v; icode = ic; ifun = fn; rA = ra; rB = rb;
      valA = a; valB = b; valC = c; valP = p; pred = pr;
   endtask

   task automatic do_reset();
      stall = 1'b0;
      drive(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, '0, '0, '0, '0, 1'b0);
      reset = 1'b1;
      #3;
      reset = 1'b0;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      f_pc = 32'h0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      total++; if (icode_out !== 4'h1) begin bad++; $display("FAIL reset_icode got=%h exp=1", icode_out); end
      total++; if (rA_out !== 4'hF || rB_out !== 4'hF) begin bad++; $display("FAIL reset_regs got=%h/%h exp=F/F", rA_out, rB_out); end
      total++; if (valE !== 0 || redirect_pc !== 0 || cnd !== 0 || wrong_pred !== 0) begin bad++; $display("FAIL reset_data valE=%h redir=%h cnd=%0b wp=%0b exp zeros", valE, redirect_pc, cnd, wrong_pred); end
      total++; if (f_pred !== 1'b0) begin bad++; $display("FAIL reset_fpred got=%0b exp=0", f_pred); end
   endtask

   task automatic test_add_overflow();
      do_reset();
      drive(1'b1, 4'h6, 4'h0, 4'h1, 4'h2, 32'h7FFF_FFFF, 32'h1, '0, 32'h8, 1'b0);
      step();
      total++; if (valE !== 32'h8000_0000) begin bad++; $display("FAIL add_valE got=%h exp=80000000", valE); end
      total++; if (out_valid !== 1'b1 || icode_out !== 4'h6) begin bad++; $display("FAIL add_ctrl valid=%0b icode=%h exp 1/6", out_valid, icode_out); end
      drive(1'b1, 4'h7, 4'h2, 4'hF, 4'hF, '0, '0, 32'h40, 32'h10, 1'b0);
      step();
      total++; if (cnd !== 1'b0) begin bad++; $display("FAIL jl_cnd got=%0b exp=0", cnd); end
      total++; if (redirect_pc !== 32'h10 || wrong_pred !== 1'b0) begin bad++; $display("FAIL jl_redir got=%h wp=%0b exp=10/0", redirect_pc, wrong_pred); end
   endtask

   task automatic test_sub_je();
      do_reset();
      drive(1'b1, 4'h6, 4'h1, 4'h1, 4'h2, 32'h5, 32'h5, '0, 32'h4, 1'b0);
      step();
      total++; if (valE !== 32'h0) begin bad++; $display("FAIL sub_valE got=%h exp=0", valE); end
      drive(1'b1, 4'h7, 4'h3, 4'hF, 4'hF, '0, '0, 32'h100, 32'h20, 1'b0);
      f_pc = 32'h20;
      #1;
      total++; if (f_pred !== 1'b0) begin bad++; $display("FAIL je_fpred_pre got=%0b exp=0", f_pred); end
      step();
      total++; if (cnd !== 1'b1 || wrong_pred !== 1'b1) begin bad++; $display("FAIL je_cnd cnd=%0b wp=%0b exp=1/1", cnd, wrong_pred); end
      total++; if (redirect_pc !== 32'h100 || valE !== 32'h0) begin bad++; $display("FAIL je_redir got=%h valE=%h exp=100/0", redirect_pc, valE); end
      total++; if (f_pred !== 1'b1) begin bad++; $display("FAIL je_fpred_post got=%0b exp=1", f_pred); end
   endtask

   task automatic test_saturation();
      logic [3:0] exp_nt [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      do_reset();
      f_pc = 32'h33;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 4'h7, 4'h0, 4'hF, 4'hF, '0, '0, 32'h80, 32'h33, 1'b1);
         step();
         total++; if (f_pred !== 1'b1) begin bad++; $display("FAIL sat_up%0d got=%0b exp=1", i, f_pred); end
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 4'h7, 4'h4, 4'hF, 4'hF, '0, '0, 32'h80, 32'h33, 1'b1);
         step();
         total++; if (f_pred !== exp_nt[i][0]) begin bad++; $display("FAIL sat_dn%0d got=%0b exp=%0b", i, f_pred, exp_nt[i][0]); end
      end
      total++; if (wrong_pred !== 1'b1 || redirect_pc !== 32'h33) begin bad++; $display("FAIL nt_redir wp=%0b redir=%h exp=1/33", wrong_pred, redirect_pc); end
      drive(1'b1, 4'h7, 4'h4, 4'hF, 4'hF, '0, '0, 32'h80, 32'h33, 1'b0);
      step();
      drive(1'b1, 4'h7, 4'h0, 4'hF, 4'hF, '0, '0, 32'h80, 32'h33, 1'b0);
      step();
      total++; if (f_pred !== 1'b0) begin bad++; $display("FAIL sat_floor1 got=%0b exp=0", f_pred); end
      step();
      total++; if (f_pred !== 1'b1) begin bad++; $display("FAIL sat_floor2 got=%0b exp=1", f_pred); end
   endtask

   task automatic test_cmov();
      do_reset();
      drive(1'b1, 4'h2, 4'h4, 4'h1, 4'h3, 32'hDEAD, '0, '0, 32'h2, 1'b0);
      step();
      total++; if (rB_out !== 4'hF || cnd !== 1'b0) begin bad++; $display("FAIL cmovne rB=%h cnd=%0b exp=F/0", rB_out, cnd); end
      total++; if (valE !== 32'hDEAD || rA_out !== 4'h1) begin bad++; $display("FAIL cmovne_val valE=%h rA=%h exp=DEAD/1", valE, rA_out); end
      drive(1'b1, 4'h2, 4'h3, 4'h1, 4'h3, 32'hBEEF, '0, '0, 32'h4, 1'b0);
      step();
      total++; if (rB_out !== 4'h3 || cnd !== 1'b1) begin bad++; $display("FAIL cmove rB=%h cnd=%0b exp=3/1", rB_out, cnd); end
   endtask

   task automatic test_alu();
      logic [3:0]    t_ic  [6] = '{4'h3, 4'h4, 4'hA, 4'h9, 4'h0, 4'h6};
      logic [3:0]    t_fn  [6] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3};
      logic [DW-1:0] t_a   [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h5, 32'hFF};
      logic [DW-1:0] t_b   [6] = '{32'h0, 32'h100, 32'h200, 32'h200, 32'h7, 32'h0F};
      logic [DW-1:0] t_c   [6] = '{32'h1234, 32'h8, 32'h0, 32'h0, 32'h9, 32'h0};
      logic [DW-1:0] t_exp [6] = '{32'h1234, 32'h108, 32'h1FC, 32'h204, 32'h0, 32'hF0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, t_ic[i], t_fn[i], 4'h0, 4'h1, t_a[i], t_b[i], t_c[i], 32'h0, 1'b0);
         step();
         total++; if (valE !== t_exp[i]) begin bad++; $display("FAIL alu%0d got=%h exp=%h", i, valE, t_exp[i]); end
      end
      // xor gave nonzero (ZF=0); ifun 7 OPl must not touch CC
      drive(1'b1, 4'h6, 4'h7, 4'h0, 4'h1, 32'h3, 32'h3, '0, '0, 1'b0);
      step();
      total++; if (valE !== 32'h0) begin bad++; $display("FAIL opl_bad_valE got=%h exp=0", valE); end
      drive(1'b1, 4'h7, 4'h3, 4'hF, 4'hF, '0, '0, 32'h40, 32'h1, 1'b0);
      step();
      total++; if (cnd !== 1'b0) begin bad++; $display("FAIL opl_bad_cc got=%0b exp=0", cnd); end
      drive(1'b1, 4'h6, 4'h2, 4'h0, 4'h1, 32'hF0, 32'h0F, '0, '0, 1'b0);
      step();
      drive(1'b1, 4'h7, 4'h3, 4'hF, 4'hF, '0, '0, 32'h40, 32'h1, 1'b0);
      step();
      total++; if (cnd !== 1'b1) begin bad++; $display("FAIL and_zf got=%0b exp=1", cnd); end
      drive(1'b1, 4'h6, 4'h1, 4'h0, 4'h1, 32'h1, 32'h8000_0000, '0, '0, 1'b0);
      step();
      total++; if (valE !== 32'h7FFF_FFFF) begin bad++; $display("FAIL subov_valE got=%h exp=7FFFFFFF", valE); end
      drive(1'b1, 4'h7, 4'h2, 4'hF, 4'hF, '0, '0, 32'h40, 32'h1, 1'b0);
      step();
      total++; if (cnd !== 1'b1) begin bad++; $display("FAIL subov_jl got=%0b exp=1", cnd); end
      drive(1'b1, 4'h7, 4'h6, 4'hF, 4'hF, '0, '0, 32'h40, 32'h1, 1'b0);
      step();
      total++; if (cnd !== 1'b0) begin bad++; $display("FAIL subov_jg got=%0b exp=0", cnd); end
   endtask

   task automatic test_stall_bubble();
      do_reset();
      drive(1'b1, 4'h6, 4'h0, 4'h1, 4'h2, 32'h2, 32'h3, '0, 32'hC, 1'b0);
      step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(i[0], 4'h6, 4'h1, 4'h4, 4'h5, 32'h9, 32'h9, '0, 32'h50, 1'b0);
         step();
         total++; if (valE !== 32'h5 || icode_out !== 4'h6 || rB_out !== 4'h2) begin bad++; $display("FAIL stall%0d valE=%h icode=%h rB=%h exp=5/6/2", i, valE, icode_out, rB_out); end
      end
      stall = 1'b0;
      drive(1'b0, 4'h6, 4'h1, 4'h4, 4'h5, 32'h9, 32'h9, '0, 32'h50, 1'b0);
      step();
      total++; if (out_valid !== 1'b0 || icode_out !== 4'h1 || rB_out !== 4'hF || valE !== 0 || valP_out !== 0) begin bad++; $display("FAIL bubble v=%0b ic=%h rB=%h valE=%h valP=%h", out_valid, icode_out, rB_out, valE, valP_out); end
      drive(1'b1, 4'h7, 4'h3, 4'hF, 4'hF, '0, '0, 32'h40, 32'h18, 1'b0);
      step();
      total++; if (cnd !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_cc cnd=%0b v=%0b exp=0/1", cnd, out_valid); end
      stall = 1'b1;
      #1;
      reset = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0 || icode_out !== 4'h1) begin bad++; $display("FAIL async_reset v=%0b ic=%h exp=0/1", out_valid, icode_out); end
      reset = 1'b0;
      stall = 1'b0;
   endtask

`ifdef EXEC_STATS_EN
   task automatic test_stats();
      do_reset();
      total++; if (br_count !== 0 || mispred_count !== 0) begin bad++; $display("FAIL stats_reset br=%0d mis=%0d exp=0/0", br_count, mispred_count); end
      drive(1'b1, 4'h7, 4'h0, 4'hF, 4'hF, '0, '0, 32'h40, 32'h1, 1'b1);
      step();
      drive(1'b1, 4'h7, 4'h0, 4'hF, 4'hF, '0, '0, 32'h40, 32'h2, 1'b0);
      step();
      stall = 1'b1;
      drive(1'b1, 4'h7, 4'h0, 4'hF, 4'hF, '0, '0, 32'h40, 32'h3, 1'b0);
      step();
      stall = 1'b0;
      drive(1'b1, 4'h7, 4'h0, 4'hF, 4'hF, '0, '0, 32'h40, 32'h4, 1'b1);
      step();
      drive(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, '0, '0, '0, '0, 1'b0);
      step();
      total++; if (br_count !== 32'd3 || mispred_count !== 32'd1) begin bad++; $display("FAIL stats br=%0d mis=%0d exp=3/1", br_count, mispred_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_add_overflow();
      test_sub_je();
      test_saturation();
      test_cmov();
      test_alu();
      test_stall_bubble();
`ifdef EXEC_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
